// File: rtl/beam_trigger_scaler.sv
// Per-beam trigger-rate scaler with gated latching readout and double-buffered thresholds on Wishbone.
// Optional per-beam trigger holdoff is compiled in when BEAM_SCALER_HOLDOFF_EN is defined.
module beam_trigger_scaler #(
    parameter int NBEAMS       = 2,
    parameter int COUNT_WIDTH  = 32,
    parameter int GATE_WIDTH   = 32,
    parameter int THRESH_WIDTH = 18
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             wb_cyc_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_we_i,
    input  logic [21:0]                      wb_adr_i,
    input  logic [31:0]                      wb_dat_i,
    input  logic [3:0]                       wb_sel_i,
    output logic                             wb_ack_o,
    output logic                             wb_err_o,
    output logic                             wb_rty_o,
    output logic [31:0]                      wb_dat_o,
    input  logic [NBEAMS-1:0]                trigger_i,
    output logic [NBEAMS*THRESH_WIDTH-1:0]   thresh_o,
    output logic                             thresh_update_o,
    output logic                             gate_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam logic [8:0]             NBEAMS_W = 9'(NBEAMS);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [GATE_WIDTH-1:0]  GATE_ONE = GATE_WIDTH'(1);

    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] dat,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
        end
        return res;
    endfunction

    state_t                  state_reg, state_next;
    logic [GATE_WIDTH-1:0]   gate_cnt_reg, gate_cnt_next;
    logic                    arm_reg, arm_next;
    logic                    done_reg, done_next;
    logic                    cont_reg;
    logic [GATE_WIDTH-1:0]   gate_len_reg;
    logic [GATE_WIDTH-1:0]   gate_len_eff;
    logic                    ack_reg, err_reg, upd_reg;
    logic [31:0]             dat_reg;

    logic [NBEAMS*COUNT_WIDTH-1:0]  readout_flat;
    logic [NBEAMS*THRESH_WIDTH-1:0] shadow_flat;

    logic [1:0]  page;
    logic [7:0]  idx;
    logic        beam_ok, access, bad, wr;
    logic [31:0] rdata;
    logic        ctrl_wr, start_now, commit_now, gate_wr;
    logic [31:0] gate_merged;
    logic        count_en;
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[21:10];
    assign page       = wb_adr_i[9:8];
    assign idx        = wb_adr_i[7:0];
    assign beam_ok    = ({1'b0, idx} < NBEAMS_W);
    // The ack/err cycle blocks re-sampling so a held request is serviced once.
    assign access     = wb_cyc_i && wb_stb_i && !ack_reg && !err_reg;
    assign wr         = access && wb_we_i && !bad;

`ifdef BEAM_SCALER_HOLDOFF_EN
    logic [15:0] holdoff_reg;
    logic        hold_wr;
    logic [31:0] hold_merged;
    assign hold_wr     = wr && (page == 2'd0) && (idx == 8'h02);
    assign hold_merged = byte_merge({16'b0, holdoff_reg}, wb_dat_i, wb_sel_i);
`endif

    always_comb begin
        bad   = 1'b1;
        rdata = '0;
        case (page)
            2'd0: begin
                case (idx)
                    8'h00: begin
                        bad   = 1'b0;
                        rdata = {29'b0, cont_reg, done_reg, (state_reg != ST_IDLE)};
                    end
                    8'h01: begin
                        bad   = 1'b0;
                        rdata = 32'(gate_len_reg);
                    end
                    8'h02: begin
                        bad   = 1'b0;
`ifdef BEAM_SCALER_HOLDOFF_EN
                        rdata = {16'b0, holdoff_reg};
`else
                        rdata = '0;
`endif
                    end
                    default: ;
                endcase
            end
            2'd1: begin
                if (beam_ok && !wb_we_i) begin
                    bad   = 1'b0;
                    rdata = 32'(readout_flat[int'(idx)*COUNT_WIDTH +: COUNT_WIDTH]);
                end
            end
            2'd2: begin
                if (beam_ok) begin
                    bad   = 1'b0;
                    rdata = 32'(shadow_flat[int'(idx)*THRESH_WIDTH +: THRESH_WIDTH]);
                end
            end
            default: ;
        endcase
    end

    assign ctrl_wr      = wr && (page == 2'd0) && (idx == 8'h00) && wb_sel_i[0];
    assign start_now    = ctrl_wr && wb_dat_i[0];
    assign commit_now   = ctrl_wr && wb_dat_i[1];
    assign gate_wr      = wr && (page == 2'd0) && (idx == 8'h01);
    assign gate_merged  = byte_merge(32'(gate_len_reg), wb_dat_i, wb_sel_i);
    assign gate_len_eff = (gate_len_reg == '0) ? GATE_ONE : gate_len_reg;
    // The ack cycle after a start is an arming cycle; counting begins one cycle later.
    assign count_en     = (state_reg == ST_RUN) && !arm_reg;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            upd_reg      <= 1'b0;
            dat_reg      <= '0;
            cont_reg     <= 1'b0;
            gate_len_reg <= '0;
        end else begin
            ack_reg <= access && !bad;
            err_reg <= access && bad;
            upd_reg <= commit_now;
            if (access) dat_reg <= bad ? 32'b0 : rdata;
            if (ctrl_wr) cont_reg <= wb_dat_i[2];
            if (gate_wr) gate_len_reg <= gate_merged[GATE_WIDTH-1:0];
        end
    end

`ifdef BEAM_SCALER_HOLDOFF_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) holdoff_reg <= '0;
        else if (hold_wr) holdoff_reg <= hold_merged[15:0];
    end
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg    <= ST_IDLE;
            gate_cnt_reg <= '0;
            arm_reg      <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gate_cnt_reg <= gate_cnt_next;
            arm_reg      <= arm_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gate_cnt_next = gate_cnt_reg;
        arm_next      = 1'b0;
        done_next     = done_reg;
        if (start_now) begin
            state_next    = ST_RUN;
            gate_cnt_next = gate_len_eff;
            arm_next      = 1'b1;
            done_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (!arm_reg) begin
                        if (gate_cnt_reg == GATE_ONE) state_next = ST_LATCH;
                        else gate_cnt_next = gate_cnt_reg - GATE_ONE;
                    end
                end
                ST_LATCH: begin
                    done_next = 1'b1;
                    if (cont_reg) begin
                        state_next    = ST_RUN;
                        gate_cnt_next = gate_len_eff;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NBEAMS; gi++) begin : g_beam
        logic [COUNT_WIDTH-1:0]  run_cnt_reg;
        logic [COUNT_WIDTH-1:0]  readout_reg;
        logic [COUNT_WIDTH-1:0]  run_inc;
        logic [THRESH_WIDTH-1:0] shadow_reg;
        logic [THRESH_WIDTH-1:0] active_reg;
        logic [31:0]             shadow_merged;
        logic                    shadow_we;
        logic                    hit;

        assign run_inc       = (run_cnt_reg == '1) ? run_cnt_reg : run_cnt_reg + CNT_ONE;
        assign shadow_we     = wr && (page == 2'd2) && (idx == 8'(gi));
        assign shadow_merged = byte_merge(32'(shadow_reg), wb_dat_i, wb_sel_i);

`ifdef BEAM_SCALER_HOLDOFF_EN
        logic [15:0] hold_reg;
        // The latch cycle opens the next continuous gate, so holdoff never spans gates.
        assign hit = trigger_i[gi] && ((state_reg == ST_LATCH) || (hold_reg == '0));
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) hold_reg <= '0;
            else if (start_now) hold_reg <= '0;
            else if (hit && (count_en || ((state_reg == ST_LATCH) && cont_reg))) hold_reg <= holdoff_reg;
            else if (state_reg == ST_LATCH) hold_reg <= '0;
            else if (hold_reg != '0) hold_reg <= hold_reg - 16'd1;
        end
`else
        assign hit = trigger_i[gi];
`endif

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                run_cnt_reg <= '0;
                readout_reg <= '0;
                shadow_reg  <= '1;
                active_reg  <= '1;
            end else begin
                if (start_now) run_cnt_reg <= '0;
                else if (state_reg == ST_LATCH) run_cnt_reg <= (cont_reg && hit) ? CNT_ONE : '0;
                else if (count_en && hit) run_cnt_reg <= run_inc;
                if (!start_now && (state_reg == ST_LATCH)) readout_reg <= run_cnt_reg;
                if (shadow_we) shadow_reg <= shadow_merged[THRESH_WIDTH-1:0];
                if (commit_now) active_reg <= shadow_reg;
            end
        end

        assign readout_flat[gi*COUNT_WIDTH +: COUNT_WIDTH]  = readout_reg;
        assign shadow_flat[gi*THRESH_WIDTH +: THRESH_WIDTH] = shadow_reg;
        assign thresh_o[gi*THRESH_WIDTH +: THRESH_WIDTH]    = active_reg;
    end

    assign wb_ack_o        = ack_reg;
    assign wb_err_o        = err_reg;
    assign wb_rty_o        = 1'b0;
    assign wb_dat_o        = dat_reg;
    assign thresh_update_o = upd_reg;
    assign gate_done_o     = (state_reg == ST_LATCH);

endmodule

// File: tb/tb_beam_trigger_scaler.sv
// Directed bench for beam_trigger_scaler: a default instance plus a 4-bit-count instance sharing one bus.
module tb_beam_trigger_scaler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [21:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [1:0]  trig;

    logic        ack, err, rty, upd, gdone;
    logic [31:0] rdat;
    logic [35:0] thresh;
    logic        ack_s, err_s, rty_s, upd_s, gdone_s;
    logic [31:0] rdat_s;
    logic [35:0] thresh_s;

    int          checks = 0;
    int          fails  = 0;
    logic        last_ack, last_err;
    logic [31:0] last_rd, last_rd_s;
    int          at;

    always #5 clk = ~clk;

    beam_trigger_scaler dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
        .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(rdat),
        .trigger_i(trig), .thresh_o(thresh), .thresh_update_o(upd), .gate_done_o(gdone)
    );

    beam_trigger_scaler #(.COUNT_WIDTH(4)) dut_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
        .wb_ack_o(ack_s), .wb_err_o(err_s), .wb_rty_o(rty_s), .wb_dat_o(rdat_s),
        .trigger_i(trig), .thresh_o(thresh_s), .thresh_update_o(upd_s), .gate_done_o(gdone_s)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, got);
        end
    endtask

    // Drives one request, returns sampled inside the ack cycle.
    task automatic wb_xfer(input logic w, input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {12'd0, a}; dat_w = d; sel = 4'hF;
        @(posedge clk); #1;
        last_ack = ack; last_err = err; last_rd = rdat; last_rd_s = rdat_s;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("bus we=%0d adr=0x%03h wdat=0x%08h ack=%0d err=%0d rdat=0x%08h", w, a, d, last_ack, last_err, last_rd);
    endtask

    task automatic wait_gate_done(input int budget, output int seen_at);
        seen_at = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (gdone) begin
                seen_at = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0; trig = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", {62'd0, ack, err}, 64'd0);
        check_eq("rst_outs", {61'd0, gdone, upd, rty}, 64'd0);
        check_eq("rst_thresh", 64'(thresh), 64'hF_FFFF_FFFF);
        check_eq("rst_dat", 64'(rdat), 64'd0);
        rst = 1'b0;

        wb_xfer(1'b0, 10'h200, 32'd0);
        check_eq("rst_shadow0", 64'(last_rd), 64'h3FFFF);
        wb_xfer(1'b0, 10'h000, 32'd0);
        check_eq("rst_ctrl", {31'd0, last_ack, last_rd}, {31'd0, 1'b1, 32'd0});

        // Shadow writes stay hidden until commit.
        wb_xfer(1'b1, 10'h200, 32'h123);
        wb_xfer(1'b1, 10'h201, 32'h456);
        check_eq("shadow_hidden", 64'(thresh), 64'hF_FFFF_FFFF);
        wb_xfer(1'b1, 10'h000, 32'h2);
        check_eq("commit_thresh", 64'(thresh), 64'({18'h456, 18'h123}));
        check_eq("commit_pulse", 64'(upd), 64'd1);
        @(posedge clk); #1;
        check_eq("commit_pulse_end", 64'(upd), 64'd0);

        // Basic gate: L=10, beam0 high 4 cycles, beam1 high 10 cycles.
        wb_xfer(1'b1, 10'h001, 32'd10);
        wb_xfer(1'b1, 10'h000, 32'h1);
        at = -1; npulse = 0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            trig[0] = (c <= 4);
            trig[1] = (c <= 10);
            if (gdone) begin
                npulse++;
                if (at < 0) at = c;
            end
        end
        trig = '0;
        check_eq("gate10_done_at", 64'(at), 64'd11);
        check_eq("gate10_npulse", 64'(npulse), 64'd1);
        wb_xfer(1'b0, 10'h100, 32'd0);
        check_eq("gate10_cnt0", 64'(last_rd), 64'd4);
        wb_xfer(1'b0, 10'h101, 32'd0);
        check_eq("gate10_cnt1", 64'(last_rd), 64'd10);
        wb_xfer(1'b0, 10'h000, 32'd0);
        check_eq("gate10_ctrl", 64'(last_rd), 64'h2);

        // Error terminations.
        wb_xfer(1'b0, 10'h102, 32'd0);
        check_eq("err_rd_oob", {62'd0, last_ack, last_err}, 64'd1);
        @(posedge clk); #1;
        check_eq("err_one_cycle", 64'(err), 64'd0);
        wb_xfer(1'b1, 10'h100, 32'hDEAD);
        check_eq("err_wr_ro", {62'd0, last_ack, last_err}, 64'd1);
        wb_xfer(1'b1, 10'h202, 32'h1);
        check_eq("err_wr_shadow_oob", {62'd0, last_ack, last_err}, 64'd1);
        wb_xfer(1'b0, 10'h100, 32'd0);
        check_eq("err_readout_kept", 64'(last_rd), 64'd4);

        // Saturation: trigger held through a 40-cycle gate.
        wb_xfer(1'b1, 10'h001, 32'd40);
        wb_xfer(1'b1, 10'h000, 32'h1);
        trig = 2'b01;
        wait_gate_done(60, at);
        trig = '0;
        check_eq("sat_done_at", 64'(at), 64'd41);
        wb_xfer(1'b0, 10'h100, 32'd0);
        check_eq("sat_cnt_wide", 64'(last_rd), 64'd40);
        check_eq("sat_cnt_4bit", 64'(last_rd_s), 64'd15);

        // Continuous: period L+1, latch-cycle trigger belongs to the next gate.
        trig = 2'b10;
        wb_xfer(1'b1, 10'h000, 32'h5);
        wait_gate_done(60, at);
        check_eq("cont_first_at", 64'(at), 64'd41);
        wait_gate_done(60, at);
        check_eq("cont_period", 64'(at), 64'd41);
        wb_xfer(1'b0, 10'h101, 32'd0);
        check_eq("cont_gate2_cnt", 64'(last_rd), 64'd41);
        check_eq("cont_gate2_4bit", 64'(last_rd_s), 64'd15);
        wb_xfer(1'b1, 10'h000, 32'h0);
        trig = '0;

        // Holdoff.
        wb_xfer(1'b1, 10'h002, 32'd3);
        check_eq("holdoff_wr_ack", 64'(last_ack), 64'd1);
        wb_xfer(1'b0, 10'h002, 32'd0);
`ifdef BEAM_SCALER_HOLDOFF_EN
        check_eq("holdoff_rd", 64'(last_rd), 64'd3);
`else
        check_eq("holdoff_rd", 64'(last_rd), 64'd0);
`endif
        wb_xfer(1'b1, 10'h001, 32'd30);
        wb_xfer(1'b1, 10'h000, 32'h1);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            trig[0] = 1'b1;
        end
        @(posedge clk); #1;
        trig = '0;
        wait_gate_done(40, at);
        check_eq("holdoff_gate_seen", 64'(at > 0), 64'd1);
        wb_xfer(1'b0, 10'h100, 32'd0);
`ifdef BEAM_SCALER_HOLDOFF_EN
        check_eq("holdoff_cnt", 64'(last_rd), 64'd5);
`else
        check_eq("holdoff_cnt", 64'(last_rd), 64'd20);
`endif

        // Zero gate length behaves as one.
        wb_xfer(1'b1, 10'h001, 32'd0);
        wb_xfer(1'b1, 10'h000, 32'h1);
        wait_gate_done(10, at);
        check_eq("gate0_done_at", 64'(at), 64'd2);

        // Reset mid-gate and mid-access.
        wb_xfer(1'b1, 10'h001, 32'd100);
        wb_xfer(1'b1, 10'h000, 32'h1);
        trig = 2'b11;
        repeat (5) @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 22'h100;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_ack", {62'd0, ack, err}, 64'd0);
        check_eq("midrst_thresh", 64'(thresh), 64'hF_FFFF_FFFF);
        check_eq("midrst_gdone", 64'(gdone), 64'd0);
        cyc = 1'b0; stb = 1'b0; trig = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        wb_xfer(1'b0, 10'h000, 32'd0);
        check_eq("midrst_ctrl", 64'(last_rd), 64'd0);
        wb_xfer(1'b0, 10'h201, 32'd0);
        check_eq("midrst_shadow1", 64'(last_rd), 64'h3FFFF);
        wb_xfer(1'b0, 10'h100, 32'd0);
        check_eq("midrst_readout", 64'(last_rd), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
